// File: rtl/if_id_queue_pkg.sv
// Shared constants for the fetch/decode instruction queue.
// Holds the legacy IF/ID defines plus the default queue depth.
package if_id_queue_pkg;

  localparam int          InstBus           = 32;
  localparam int          InstAddrBus       = 32;
  localparam int          INT_BUS           = 8;
  localparam logic [31:0] INST_NOP          = 32'h0000_0013;
  localparam logic [31:0] ZeroWord          = 32'h0000_0000;
  localparam logic [7:0]  INT_NONE          = 8'h00;
  localparam int          IFQ_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/if_id_queue_storage.sv
// Register array for queued instruction entries.
// One synchronous write port and one asynchronous read port; the array is not reset.
module ifq_storage #(
  parameter int DEPTH = 4,
  parameter int DW    = 73,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_id_queue.sv
// DEPTH-entry IF/ID instruction queue with valid/ready on both sides and one-cycle flush.
// Define IFQ_BYPASS_EN for zero-latency fall-through when the queue is empty.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH  = IFQ_DEPTH_DEFAULT,
  parameter int INST_W = InstBus,
  parameter int ADDR_W = InstAddrBus,
  parameter int INT_W  = INT_BUS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [INST_W-1:0]        inst_i,
  input  logic [ADDR_W-1:0]        inst_addr_i,
  input  logic [INT_W-1:0]         int_flag_i,
  input  logic                     prdt_taken_i,
  input  logic                     flush_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [INST_W-1:0]        inst_o,
  output logic [ADDR_W-1:0]        inst_addr_o,
  output logic [INT_W-1:0]         int_flag_o,
  output logic                     prdt_taken_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = INST_W + ADDR_W + INT_W + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty, push, pop, bypass, wr_en, rd_adv;
  logic [DW-1:0] wdata, rdata;

  assign empty      = (count_q == '0);
  assign in_ready_o = (count_q != CW'(DEPTH));

`ifdef IFQ_BYPASS_EN
  // Empty queue: the incoming entry is presented straight to decode.
  assign bypass      = empty;
  assign out_valid_o = empty ? (in_valid_i & ~flush_i) : 1'b1;
`else
  assign bypass      = 1'b0;
  assign out_valid_o = ~empty;
`endif

  assign push   = in_valid_i & in_ready_o & ~flush_i;
  assign pop    = out_valid_o & out_ready_i & ~flush_i;
  assign wr_en  = push & ~(bypass & pop);
  assign rd_adv = pop & ~bypass;
  assign wdata  = {inst_i, inst_addr_i, int_flag_i, prdt_taken_i};

  ifq_storage #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_storage (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (wdata),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en)  wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_adv) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en, rd_adv})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Empty slots are never read out, so uninitialised storage stays hidden.
  always_comb begin
    inst_o       = INST_W'(INST_NOP);
    inst_addr_o  = ADDR_W'(ZeroWord);
    int_flag_o   = INT_W'(INT_NONE);
    prdt_taken_o = 1'b0;
    if (bypass && out_valid_o) begin
      {inst_o, inst_addr_o, int_flag_o, prdt_taken_o} = wdata;
    end else if (!empty) begin
      {inst_o, inst_addr_o, int_flag_o, prdt_taken_o} = rdata;
    end
  end

  assign count_o = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_if_id_queue;

  localparam int D = 4;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic [7:0]  intf;
    logic        pt;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i, in_ready_o, prdt_taken_i, flush_i;
  logic        out_valid_o, out_ready_i, prdt_taken_o;
  logic [31:0] inst_i, inst_addr_i, inst_o, inst_addr_o;
  logic [7:0]  int_flag_i, int_flag_o;
  logic [2:0]  count_o;

  int   checks   = 0;
  int   failures = 0;
  ent_t q[$];

  if_id_queue #(.DEPTH(D), .INST_W(32), .ADDR_W(32), .INT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .inst_i       (inst_i),
    .inst_addr_i  (inst_addr_i),
    .int_flag_i   (int_flag_i),
    .prdt_taken_i (prdt_taken_i),
    .flush_i      (flush_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .int_flag_o   (int_flag_o),
    .prdt_taken_o (prdt_taken_o),
    .count_o      (count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check outputs against the model, then advance the model at the edge.
  task automatic cyc(input logic vld, input logic [31:0] inst, input logic [31:0] addr,
                     input logic [7:0] intf, input logic pt, input logic fl, input logic ordy);
    ent_t e, exp_e;
    logic exp_rdy, exp_vld, do_push, do_pop, was_empty, byp;
    e = '{inst: inst, addr: addr, intf: intf, pt: pt};
    in_valid_i = vld; inst_i = inst; inst_addr_i = addr; int_flag_i = intf;
    prdt_taken_i = pt; flush_i = fl; out_ready_i = ordy;
    was_empty = (q.size() == 0);
    exp_rdy   = (q.size() != D);
`ifdef IFQ_BYPASS_EN
    byp = was_empty;
`else
    byp = 1'b0;
`endif
    exp_vld = was_empty ? (byp & vld & ~fl) : 1'b1;
    if (!was_empty)   exp_e = q[0];
    else if (exp_vld) exp_e = e;
    else              exp_e = '{inst: 32'h0000_0013, addr: 32'h0, intf: 8'h00, pt: 1'b0};
    #2;
    chk("in_ready", in_ready_o, exp_rdy);
    chk("out_valid", out_valid_o, exp_vld);
    chk("count", count_o, q.size());
    chk("inst", inst_o, exp_e.inst);
    chk("inst_addr", inst_addr_o, exp_e.addr);
    chk("int_flag", int_flag_o, exp_e.intf);
    chk("prdt_taken", prdt_taken_o, exp_e.pt);
    do_push = vld & exp_rdy & ~fl;
    do_pop  = exp_vld & ordy & ~fl;
    @(posedge clk);
    if (fl) q.delete();
    else if (!(byp && do_pop)) begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
    #1;
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, 32'h0, 32'h0, 8'h0, 1'b0, 1'b0, ordy);
  endtask

  initial begin
    rst = 1'b0; in_valid_i = 0; inst_i = 0; inst_addr_i = 0; int_flag_i = 0;
    prdt_taken_i = 0; flush_i = 0; out_ready_i = 0;
    #2;
    chk("rst_count", count_o, 3'd0);
    chk("rst_valid", out_valid_o, 1'b0);
    chk("rst_ready", in_ready_o, 1'b1);
    chk("rst_inst", inst_o, 32'h0000_0013);
    @(posedge clk); #1;
    rst = 1'b1;

    // Reset mid-stream with three entries queued
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'hA0 + i, 32'(i * 4), 8'h0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_count", count_o, 3'd3);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_count", count_o, 3'd0);
    chk("async_rst_valid", out_valid_o, 1'b0);
    chk("async_rst_inst", inst_o, 32'h0000_0013);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b1;

    // Fill to full, offer a fifth entry, then drain in order
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 32'h11 * (i + 1), 32'(i * 4), 8'h0, 1'b0, 1'b0, 1'b0);
    chk("full_ready", in_ready_o, 1'b0);
    chk("full_count", count_o, 3'd4);
    cyc(1'b1, 32'h99, 32'h10, 8'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1);
    idle(1'b1);

    // Steady push+pop at occupancy two, wrapping pointers
    for (int i = 0; i < 2; i++) cyc(1'b1, 32'h100 + i, 32'h400 + 32'(i * 4), 8'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 2; i < 12; i++) cyc(1'b1, 32'h100 + i, 32'h400 + 32'(i * 4), 8'h0, 1'b0, 1'b0, 1'b1);
    chk("stream_count", count_o, 3'd2);
    idle(1'b1); idle(1'b1); idle(1'b1);

    // Flush with a concurrent push at occupancy three
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h200 + i, 32'h800 + 32'(i * 4), 8'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h55, 32'hC00, 8'h0, 1'b0, 1'b1, 1'b1);
    chk("flush_count", count_o, 3'd0);
    chk("flush_valid", out_valid_o, 1'b0);
    idle(1'b1); idle(1'b1);

    // Sideband fields travel with their entry
    cyc(1'b1, 32'h0000_0073, 32'h40, 8'h01, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

`ifdef IFQ_BYPASS_EN
    // Fall-through on an empty queue
    in_valid_i = 1'b1; inst_i = 32'h77; inst_addr_i = 32'h80; int_flag_i = 8'h0;
    prdt_taken_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
    #2;
    chk("byp_valid", out_valid_o, 1'b1);
    chk("byp_inst", inst_o, 32'h77);
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    chk("byp_count", count_o, 3'd0);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), $urandom, $urandom, 8'($urandom), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
